// File: rtl/ddr4_instr_packer.sv
// DDR4 instruction packer: folds a stream of 32-bit SoftMC instructions into
// multi-phase DFI command bundles. A bundle is emitted when all phases are
// filled, on a flush request, or after an idle timeout.
// Optional build macro: DDR4_BANK_TRACK_EN adds an open-bank map that flags
// protocol-illegal commands on err_illegal (sticky until rst).
module ddr4_instr_packer #(
    parameter int NUM_PHASES   = 4,
    parameter int ROW_WIDTH    = 17,
    parameter int BANK_WIDTH   = 2,
    parameter int BG_WIDTH     = 2,
    parameter int CS_WIDTH     = 1,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [31:0]                      instr,
    input  logic                             instr_valid,
    output logic                             instr_ready,
    input  logic                             flush,
    output logic                             dfi_valid,
    input  logic                             dfi_ready,
    output logic [NUM_PHASES-1:0]            dfi_act_n,
    output logic [NUM_PHASES*17-1:0]         dfi_address,
    output logic [NUM_PHASES*BANK_WIDTH-1:0] dfi_bank,
    output logic [NUM_PHASES*BG_WIDTH-1:0]   dfi_bg,
    output logic [NUM_PHASES*CS_WIDTH-1:0]   dfi_cs_n,
    output logic [NUM_PHASES-1:0]            dfi_rdcas,
    output logic [NUM_PHASES-1:0]            dfi_wrcas,
    output logic                             err_illegal
);

    // SoftMC instruction field offsets. Row/column bits sit at the bottom,
    // bank and bank group directly above the row field.
    localparam int ROW_OFFSET = 17;
    localparam int WE_OFFSET  = 24;
    localparam int CAS_OFFSET = 25;
    localparam int RAS_OFFSET = 26;
    localparam int CS_OFFSET  = 27;

    localparam int ADDR_W = 17;
    localparam int CNT_W  = $clog2(NUM_PHASES + 1);
    localparam int PH_W   = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam int IDLE_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_PHASES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

    // {RAS, CAS, WE} encodings, 1 = high
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;

    typedef struct packed {
        logic                  act_n;
        logic [ADDR_W-1:0]     addr;
        logic [BANK_WIDTH-1:0] bank;
        logic [BG_WIDTH-1:0]   bg;
        logic [CS_WIDTH-1:0]   cs_n;
        logic                  rdcas;
        logic                  wrcas;
    } phase_t;

    // Deselect: no chip selected, no activate, no column strobes.
    localparam phase_t PH_DES = {1'b1, {ADDR_W{1'b0}}, {BANK_WIDTH{1'b0}},
                                 {BG_WIDTH{1'b0}}, {CS_WIDTH{1'b1}}, 2'b00};

    logic [2:0]        cmd;
    phase_t            ph_in;
    phase_t            acc_q [NUM_PHASES];
    phase_t            acc_d [NUM_PHASES];
    phase_t            out_q [NUM_PHASES];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PH_W-1:0]   wr_idx;
    logic              flush_pend_q, flush_pend_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              dfi_valid_q;
    logic              has_data, cnt_full, timeout_hit, out_free, xfer, accept;
    logic              unused_instr;

    // Several instruction bits carry fields this block does not forward.
    assign unused_instr = ^instr;

    assign cmd = {instr[RAS_OFFSET], instr[CAS_OFFSET], instr[WE_OFFSET]};

    // Translate the offered instruction into one DFI phase.
    always_comb begin
        ph_in       = PH_DES;
        ph_in.act_n = (cmd != CMD_ACT);
        if (cmd == CMD_ACT) begin
            ph_in.addr = ADDR_W'(instr[ROW_WIDTH-1:0]);
        end else begin
            // A16/A15/A14 double as RAS/CAS/WE for non-activate commands
            ph_in.addr = {cmd, instr[13:0]};
        end
        ph_in.bank  = instr[ROW_OFFSET +: BANK_WIDTH];
        ph_in.bg    = instr[ROW_OFFSET + BANK_WIDTH +: BG_WIDTH];
        ph_in.cs_n  = instr[CS_OFFSET +: CS_WIDTH];
        ph_in.rdcas = (cmd == CMD_RD);
        ph_in.wrcas = (cmd == CMD_WR);
    end

    assign has_data    = (count_q != '0);
    assign cnt_full    = (count_q == CNT_FULL);
    assign timeout_hit = (IDLE_TIMEOUT != 0) && (idle_q == IDLE_MAX);
    assign out_free    = !dfi_valid_q || dfi_ready;
    assign xfer        = has_data && (cnt_full || flush_pend_q || timeout_hit) && out_free;
    // A full accumulator can still take an instruction in the cycle it drains.
    assign instr_ready = !cnt_full || xfer;
    assign accept      = instr_valid && instr_ready;

    // Accumulator next state: drain on transfer, then append the accepted phase.
    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        wr_idx  = '0;
        if (xfer) begin
            for (int p = 0; p < NUM_PHASES; p++) begin
                acc_d[p] = PH_DES;
            end
            count_d = '0;
        end
        if (accept) begin
            wr_idx        = count_d[PH_W-1:0];
            acc_d[wr_idx] = ph_in;
            count_d       = count_d + CNT_ONE;
        end
    end

    // Flush is remembered only if there is, or will be, something to flush.
    always_comb begin
        if (xfer) begin
            flush_pend_d = flush && accept;
        end else begin
            flush_pend_d = flush_pend_q || (flush && (has_data || accept));
        end
    end

    // Idle counter saturates at the timeout so a blocked output keeps the hit.
    always_comb begin
        idle_d = idle_q;
        if (accept || xfer || !has_data) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_ONE;
        end
    end

    // Accumulator and control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PHASES; p++) begin
                acc_q[p] <= PH_DES;
            end
            count_q      <= '0;
            flush_pend_q <= 1'b0;
            idle_q       <= '0;
        end else begin
            acc_q        <= acc_d;
            count_q      <= count_d;
            flush_pend_q <= flush_pend_d;
            idle_q       <= idle_d;
        end
    end

    // Output bundle register: loaded on transfer, held until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            dfi_valid_q <= 1'b0;
            for (int p = 0; p < NUM_PHASES; p++) begin
                out_q[p] <= PH_DES;
            end
        end else if (xfer) begin
            dfi_valid_q <= 1'b1;
            out_q       <= acc_q;
        end else if (dfi_ready) begin
            dfi_valid_q <= 1'b0;
        end
    end

    assign dfi_valid = dfi_valid_q;

    for (genvar p = 0; p < NUM_PHASES; p++) begin : g_phase
        assign dfi_act_n[p]                        = out_q[p].act_n;
        assign dfi_address[p*ADDR_W +: ADDR_W]     = out_q[p].addr;
        assign dfi_bank[p*BANK_WIDTH +: BANK_WIDTH] = out_q[p].bank;
        assign dfi_bg[p*BG_WIDTH +: BG_WIDTH]       = out_q[p].bg;
        assign dfi_cs_n[p*CS_WIDTH +: CS_WIDTH]     = out_q[p].cs_n;
        assign dfi_rdcas[p]                        = out_q[p].rdcas;
        assign dfi_wrcas[p]                        = out_q[p].wrcas;
    end

`ifdef DDR4_BANK_TRACK_EN
    localparam int         BIDX_W  = BG_WIDTH + BANK_WIDTH;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;

    logic [(1<<BIDX_W)-1:0] open_q, open_d;
    logic                   err_q, err_d;
    logic [BIDX_W-1:0]      bidx;

    assign bidx = {ph_in.bg, ph_in.bank};

    // Open-bank bookkeeping in acceptance order; bad commands still pass through.
    always_comb begin
        open_d = open_q;
        err_d  = err_q;
        if (accept) begin
            case (cmd)
                CMD_ACT: begin
                    if (open_q[bidx]) err_d = 1'b1;
                    open_d[bidx] = 1'b1;
                end
                CMD_PRE: begin
                    if (instr[10]) open_d = '0;
                    else           open_d[bidx] = 1'b0;
                end
                CMD_RD, CMD_WR: begin
                    if (!open_q[bidx]) err_d = 1'b1;
                end
                CMD_REF: begin
                    if (|open_q) err_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Open-bank map and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            open_q <= '0;
            err_q  <= 1'b0;
        end else begin
            open_q <= open_d;
            err_q  <= err_d;
        end
    end

    assign err_illegal = err_q;
`else
    assign err_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ddr4_instr_packer.sv
// Self-checking bench for ddr4_instr_packer (default parameters).
// A queue-based reference model predicts ready/valid/bundles every cycle;
// directed tables and sequences cover decode and the multi-cycle corners.
module tb_ddr4_instr_packer;

    localparam int NP = 4;
    localparam int AW = NP * 17;
    localparam int TO = 16;

    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;

    logic          clk = 1'b0;
    logic          rst, instr_valid, instr_ready, flush, dfi_valid, dfi_ready, err_illegal;
    logic [31:0]   instr;
    logic [NP-1:0] dfi_act_n, dfi_rdcas, dfi_wrcas, dfi_cs_n;
    logic [AW-1:0] dfi_address;
    logic [2*NP-1:0] dfi_bank, dfi_bg;

    always #5 clk = ~clk;

    ddr4_instr_packer dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .flush(flush), .dfi_valid(dfi_valid),
        .dfi_ready(dfi_ready), .dfi_act_n(dfi_act_n), .dfi_address(dfi_address),
        .dfi_bank(dfi_bank), .dfi_bg(dfi_bg), .dfi_cs_n(dfi_cs_n),
        .dfi_rdcas(dfi_rdcas), .dfi_wrcas(dfi_wrcas), .err_illegal(err_illegal)
    );

    typedef struct packed {
        logic [NP-1:0]   act_n;
        logic [AW-1:0]   addr;
        logic [2*NP-1:0] bank;
        logic [2*NP-1:0] bg;
        logic [NP-1:0]   cs_n;
        logic [NP-1:0]   rd;
        logic [NP-1:0]   wr;
    } bundle_t;

    typedef struct {
        logic [2:0]  cmd;
        logic [16:0] row;
        logic [1:0]  bank;
        logic [1:0]  bg;
        logic        cs_n;
        logic        exp_act_n;
        logic [16:0] exp_addr;
        logic        exp_rd;
        logic        exp_wr;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    logic [31:0] m_acc[$];
    logic        m_fp, m_valid, m_err;
    int          m_idle;
    bundle_t     m_out;
    logic [15:0] m_open;

    // last sampled outputs
    logic    s_valid, s_acc;
    bundle_t s_out;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] c, input logic [16:0] row,
                                       input logic [1:0] bank, input logic [1:0] bg, input logic cs);
        logic [31:0] r;
        r = '0;
        r[16:0]  = row;
        r[18:17] = bank;
        r[20:19] = bg;
        r[26:24] = c;
        r[27]    = cs;
        return r;
    endfunction

    function automatic bundle_t des_bundle();
        bundle_t b;
        b = '0;
        b.act_n = '1;
        b.cs_n  = '1;
        return b;
    endfunction

    // Bundle the model's accumulated instructions, unfilled phases deselected.
    function automatic bundle_t encode_acc();
        bundle_t     b;
        logic [31:0] w;
        logic [2:0]  c;
        b = des_bundle();
        for (int p = 0; p < m_acc.size(); p++) begin
            w = m_acc[p];
            c = w[26:24];
            b.act_n[p]          = (c != C_ACT);
            b.addr[p*17 +: 17]  = (c == C_ACT) ? w[16:0] : {c, w[13:0]};
            b.bank[p*2 +: 2]    = w[18:17];
            b.bg[p*2 +: 2]      = w[20:19];
            b.cs_n[p]           = w[27];
            b.rd[p]             = (c == C_RD);
            b.wr[p]             = (c == C_WR);
        end
        return b;
    endfunction

    task automatic track(input logic [31:0] w);
`ifdef DDR4_BANK_TRACK_EN
        logic [3:0] b;
        b = {w[20:19], w[18:17]};
        case (w[26:24])
            C_ACT: begin if (m_open[b]) m_err = 1'b1; m_open[b] = 1'b1; end
            C_PRE: begin if (w[10]) m_open = '0; else m_open[b] = 1'b0; end
            C_RD, C_WR: if (!m_open[b]) m_err = 1'b1;
            C_REF: if (|m_open) m_err = 1'b1;
            default: ;
        endcase
`else
        if (w[31]) m_open = m_open;
`endif
    endtask

    task automatic model_clear();
        m_acc.delete();
        m_fp = 0; m_valid = 0; m_err = 0; m_idle = 0; m_open = '0;
        m_out = des_bundle();
    endtask

    // One clock cycle: check outputs, apply inputs, check ready, advance model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic fl, input logic rdy);
        logic xf, rd_exp, acc;
        int   c0;
        @(negedge clk);
        s_valid = dfi_valid;
        s_out   = {dfi_act_n, dfi_address, dfi_bank, dfi_bg, dfi_cs_n, dfi_rdcas, dfi_wrcas};
        chk("dfi_valid", 128'(dfi_valid), 128'(m_valid));
        if (m_valid) chk("bundle", 128'(s_out), 128'(m_out));
        chk("err_illegal", 128'(err_illegal), 128'(m_err));
        instr_valid = v; instr = ins; flush = fl; dfi_ready = rdy;
        #1;
        c0 = m_acc.size();
        xf = (c0 > 0) && (c0 == NP || m_fp || m_idle == TO) && (!m_valid || rdy);
        rd_exp = (c0 < NP) || xf;
        chk("instr_ready", 128'(instr_ready), 128'(rd_exp));
        acc   = v && rd_exp;
        s_acc = acc;
        @(posedge clk);
        if (acc || xf || c0 == 0) m_idle = 0;
        else if (m_idle < TO) m_idle++;
        if (xf) m_fp = fl && acc;
        else    m_fp = m_fp || (fl && (c0 > 0 || acc));
        if (xf) begin
            m_out   = encode_acc();
            m_valid = 1'b1;
            m_acc.delete();
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        if (acc) begin
            track(ins);
            m_acc.push_back(ins);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; instr_valid = 1'b0; flush = 1'b0; dfi_ready = 1'b1;
        repeat (n) @(posedge clk);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic wait_bundle(input string nm, input int maxc, output logic found);
        found = 1'b0;
        for (int k = 0; k < maxc && !found; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            if (s_valid) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no bundle within %0d cycles", nm, maxc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[6];
        logic        found, exp_err, have;
        int          seen, n_acc, held_n, held_bad;
        bundle_t     first;
        logic [AW-1:0] exp_addr;
        logic [2:0]  cmds[5];
        logic [31:0] ins;
        logic        v, fl, rdy;

        vt[0] = '{C_ACT, 17'h1ABCD, 2'd1, 2'd2, 1'b0, 1'b0, 17'h1ABCD, 1'b0, 1'b0};
        vt[1] = '{C_RD,  17'h1C123, 2'd3, 2'd0, 1'b0, 1'b1, 17'h14123, 1'b1, 1'b0};
        vt[2] = '{C_WR,  17'h0FFFF, 2'd0, 2'd3, 1'b0, 1'b1, 17'h13FFF, 1'b0, 1'b1};
        vt[3] = '{C_PRE, 17'h00400, 2'd2, 2'd1, 1'b0, 1'b1, 17'h08400, 1'b0, 1'b0};
        vt[4] = '{C_REF, 17'h1FFFF, 2'd0, 2'd0, 1'b1, 1'b1, 17'h07FFF, 1'b0, 1'b0};
        vt[5] = '{C_ACT, 17'h00001, 2'd3, 2'd3, 1'b0, 1'b0, 17'h00001, 1'b0, 1'b0};
        cmds = '{C_ACT, C_RD, C_WR, C_PRE, C_REF};

        rst = 1'b1; instr_valid = 1'b0; instr = '0; flush = 1'b0; dfi_ready = 1'b1;
        model_clear();
        do_reset(3);

        // reset state
        chk("rst_valid", 128'(dfi_valid), 128'(0));
        chk("rst_act_n", 128'(dfi_act_n), 128'(4'hF));
        chk("rst_cs_n", 128'(dfi_cs_n), 128'(4'hF));
        chk("rst_addr", 128'(dfi_address), 128'(0));
        chk("rst_cas", 128'({dfi_rdcas, dfi_wrcas}), 128'(0));
        chk("rst_ready", 128'(instr_ready), 128'(1));
        chk("rst_err", 128'(err_illegal), 128'(0));

        // single-command decode table, flushed in the accept cycle
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, mk(vt[i].cmd, vt[i].row, vt[i].bank, vt[i].bg, vt[i].cs_n), 1'b1, 1'b1);
            wait_bundle("tbl_emit", 6, found);
            if (found) begin
                chk("tbl_act_n", 128'(s_out.act_n[0]), 128'(vt[i].exp_act_n));
                chk("tbl_addr", 128'(s_out.addr[16:0]), 128'(vt[i].exp_addr));
                chk("tbl_bank", 128'(s_out.bank[1:0]), 128'(vt[i].bank));
                chk("tbl_bg", 128'(s_out.bg[1:0]), 128'(vt[i].bg));
                chk("tbl_cs_n", 128'(s_out.cs_n[0]), 128'(vt[i].cs_n));
                chk("tbl_rdcas", 128'(s_out.rd[0]), 128'(vt[i].exp_rd));
                chk("tbl_wrcas", 128'(s_out.wr[0]), 128'(vt[i].exp_wr));
                chk("tbl_des_rest", 128'({s_out.act_n[3:1], s_out.cs_n[3:1]}), 128'(6'b111111));
            end
        end
        idle(2);

        // four back-to-back activates form one full bundle
        do_reset(2);
        cycle(1'b1, mk(C_ACT, 17'h00011, 2'd0, 2'd0, 1'b0), 1'b0, 1'b1);
        cycle(1'b1, mk(C_ACT, 17'h1F000, 2'd1, 2'd0, 1'b0), 1'b0, 1'b1);
        cycle(1'b1, mk(C_ACT, 17'h0ABCD, 2'd2, 2'd0, 1'b0), 1'b0, 1'b1);
        cycle(1'b1, mk(C_ACT, 17'h10001, 2'd3, 2'd0, 1'b0), 1'b0, 1'b1);
        wait_bundle("act4_emit", 4, found);
        if (found) begin
            exp_addr = {17'h10001, 17'h0ABCD, 17'h1F000, 17'h00011};
            chk("act4_act_n", 128'(s_out.act_n), 128'(4'b0000));
            chk("act4_addr", 128'(s_out.addr), 128'(exp_addr));
            seen = 0;
            for (int k = 0; k < 3; k++) begin
                cycle(1'b0, 32'h0, 1'b0, 1'b1);
                if (s_valid) seen++;
            end
            chk("act4_single_pulse", 128'(seen), 128'(0));
        end

        // one read then a separate flush
        do_reset(2);
        cycle(1'b1, mk(C_RD, 17'h00055, 2'd3, 2'd1, 1'b0), 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        wait_bundle("rd_flush_emit", 4, found);
        if (found) begin
            chk("rd_flush_a16_14", 128'(s_out.addr[16:14]), 128'(3'b101));
            chk("rd_flush_rdcas", 128'(s_out.rd), 128'(4'b0001));
            chk("rd_flush_wrcas", 128'(s_out.wr), 128'(4'b0000));
            chk("rd_flush_des_addr", 128'(s_out.addr[AW-1:17]), 128'(0));
            chk("rd_flush_des_ctl", 128'({s_out.act_n[3:1], s_out.cs_n[3:1]}), 128'(6'b111111));
            chk("rd_flush_des_bank", 128'({s_out.bank[7:2], s_out.bg[7:2]}), 128'(0));
        end

        // two writes then idle: auto-emit exactly after the timeout
        do_reset(2);
        cycle(1'b1, mk(C_WR, 17'h00100, 2'd0, 2'd0, 1'b0), 1'b0, 1'b1);
        cycle(1'b1, mk(C_WR, 17'h00200, 2'd1, 2'd0, 1'b0), 1'b0, 1'b1);
        seen = 0;
        for (int k = 0; k < 17; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            if (s_valid) seen++;
        end
        chk("timeout_early", 128'(seen), 128'(0));
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("timeout_emit", 128'(s_valid), 128'(1));
        chk("timeout_wrcas", 128'(s_out.wr), 128'(4'b0011));

        // back-pressure: eight accepts, first bundle held steady
        do_reset(2);
        n_acc = 0; have = 0; held_n = 0; held_bad = 0; first = '0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, mk(C_ACT, 17'(17'h100 + k), k[1:0], k[3:2], 1'b0), 1'b0, 1'b0);
            if (s_acc) n_acc++;
            if (s_valid) begin
                if (!have) begin
                    first = s_out;
                    have  = 1'b1;
                end else begin
                    held_n++;
                    if (s_out !== first) held_bad++;
                end
            end
        end
        chk("bp_accepts", 128'(n_acc), 128'(8));
        chk("bp_held_cycles", 128'(held_n), 128'(4));
        chk("bp_held_stable", 128'(held_bad), 128'(0));
        chk("bp_first_row", 128'(first.addr[16:0]), 128'(17'h100));
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("bp_release_first", 128'(s_out.addr), 128'(first.addr));
        wait_bundle("bp_second", 3, found);
        if (found) begin
            chk("bp_second_p0", 128'(s_out.addr[16:0]), 128'(17'h104));
            chk("bp_second_p3", 128'(s_out.addr[67:51]), 128'(17'h107));
        end
        idle(2);

        // read to a never-activated bank
        do_reset(2);
`ifdef DDR4_BANK_TRACK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        cycle(1'b1, mk(C_RD, 17'h00000, 2'd3, 2'd0, 1'b0), 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("err_next_cycle", 128'(err_illegal), 128'(exp_err));
        idle(5);
        chk("err_sticky", 128'(err_illegal), 128'(exp_err));

        // reset mid-accumulation discards pending phases
        do_reset(2);
        cycle(1'b1, mk(C_ACT, 17'h0DEAD, 2'd0, 2'd1, 1'b0), 1'b0, 1'b1);
        cycle(1'b1, mk(C_ACT, 17'h0BEEF, 2'd1, 2'd1, 1'b0), 1'b0, 1'b1);
        do_reset(1);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 32'h0, k == 0, 1'b1);
            if (s_valid) seen++;
        end
        chk("rst_mid_no_emit", 128'(seen), 128'(0));
        for (int k = 0; k < 4; k++)
            cycle(1'b1, mk(C_ACT, 17'(17'h00A00 + k), k[1:0], 2'd2, 1'b0), 1'b0, 1'b1);
        wait_bundle("rst_mid_clean", 3, found);
        if (found) begin
            chk("rst_mid_p0", 128'(s_out.addr[16:0]), 128'(17'h00A00));
            chk("rst_mid_p3", 128'(s_out.addr[67:51]), 128'(17'h00A03));
        end

        // randomized traffic against the model, with idle stretches
        do_reset(2);
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            if ((i / 40) % 3 == 2) begin
                v  = 1'b0;
                fl = 1'b0;
            end
            ins = mk(cmds[$urandom_range(0, 4)], 17'($urandom), 2'($urandom), 2'($urandom),
                     1'($urandom_range(0, 7) == 0));
            ins = ins | ($urandom & 32'hF0E0_0000);
            cycle(v, ins, fl, rdy);
        end
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
